// File: rtl/password_lockout_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : password_lockout_fsm
//  Description : Attempt controller placed after the password checker. Turns
//                the check button into a one-cycle check strobe, counts
//                consecutive failures, grants a timed unlock window on a
//                match and imposes a timed lockout after MAX_TRIES failures.
//  Revision    : 1.0 - initial release
// ============================================================================
module password_lockout_fsm #(
    parameter int TICK_DIV    = 100_000_000,  // clk cycles per one-second tick (>=2)
    parameter int MAX_TRIES   = 3,            // consecutive failures before lockout (1..15)
    parameter int LOCK_SECS   = 30,           // lockout duration in seconds (1..255)
    parameter int UNLOCK_SECS = 10            // unlock window in seconds (1..255)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       check_btn,
    input  logic       relock_btn,
    input  logic       has_pass,
    input  logic       match,
    output logic       check_strobe,
    output logic [1:0] state,
    output logic       unlocked,
    output logic       locked_out,
    output logic [3:0] fail_count,
    output logic [7:0] secs_left,
    output logic       alarm
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0] C_TICK_LAST   = PW'(TICK_DIV - 1);
    localparam logic [3:0]    C_MAX_TRIES   = 4'(MAX_TRIES);
    localparam logic [7:0]    C_LOCK_SECS   = 8'(LOCK_SECS);
    localparam logic [7:0]    C_UNLOCK_SECS = 8'(UNLOCK_SECS);

    localparam logic [1:0] C_ST_NOPASS   = 2'b00;
    localparam logic [1:0] C_ST_LOCKED   = 2'b01;
    localparam logic [1:0] C_ST_UNLOCKED = 2'b10;
    localparam logic [1:0] C_ST_LOCKOUT  = 2'b11;

    logic [1:0]    state_q,  state_d;
    logic [3:0]    fail_q,   fail_d;
    logic [7:0]    secs_q,   secs_d;
    logic [PW-1:0] presc_q,  presc_d;
    logic          alarm_q,  alarm_d;
    logic          check_q;
    logic          relock_q;

    logic w_check_rise;
    logic w_relock_rise;
    logic w_strobe;
    logic w_tick;
    logic w_expire;

    assign w_check_rise  = check_btn  & ~check_q;
    assign w_relock_rise = relock_btn & ~relock_q;
    assign w_strobe      = w_check_rise & has_pass & (state_q == C_ST_LOCKED);
    assign w_tick        = (presc_q == C_TICK_LAST);
    // Last second elapses on this edge: window ends together with secs_left->0
    assign w_expire      = w_tick && (secs_q == 8'd1);

    // State register plus timer, counter and button-edge registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= C_ST_NOPASS;
            fail_q   <= 4'd0;
            secs_q   <= 8'd0;
            presc_q  <= '0;
            alarm_q  <= 1'b0;
            check_q  <= 1'b0;
            relock_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fail_q   <= fail_d;
            secs_q   <= secs_d;
            presc_q  <= presc_d;
            alarm_q  <= alarm_d;
            check_q  <= check_btn;
            relock_q <= relock_btn;
        end
    end

    // Next-state logic: has_pass=0 overrides everything, timers run only in timed states
    always_comb begin
        state_d = state_q;
        fail_d  = fail_q;
        secs_d  = secs_q;
        presc_d = '0;
        alarm_d = 1'b0;

        if (!has_pass) begin
            state_d = C_ST_NOPASS;
            fail_d  = 4'd0;
            secs_d  = 8'd0;
        end else begin
            case (state_q)
                C_ST_NOPASS: begin
                    state_d = C_ST_LOCKED;
                end
                C_ST_LOCKED: begin
                    if (w_strobe) begin
                        if (match) begin
                            state_d = C_ST_UNLOCKED;
                            fail_d  = 4'd0;
                            secs_d  = C_UNLOCK_SECS;
                        end else if ((fail_q + 4'd1) == C_MAX_TRIES) begin
                            state_d = C_ST_LOCKOUT;
                            fail_d  = C_MAX_TRIES;
                            secs_d  = C_LOCK_SECS;
                            alarm_d = 1'b1;
                        end else begin
                            fail_d  = fail_q + 4'd1;
                        end
                    end
                end
                C_ST_UNLOCKED: begin
                    presc_d = w_tick ? '0 : presc_q + PW'(1);
                    if (w_tick) begin
                        secs_d = secs_q - 8'd1;
                    end
                    if (w_relock_rise || w_expire) begin
                        state_d = C_ST_LOCKED;
                        secs_d  = 8'd0;
                        presc_d = '0;
                    end
                end
                C_ST_LOCKOUT: begin
                    presc_d = w_tick ? '0 : presc_q + PW'(1);
                    if (w_tick) begin
                        secs_d = secs_q - 8'd1;
                    end
                    if (w_expire) begin
                        state_d = C_ST_LOCKED;
                        fail_d  = 4'd0;
                        secs_d  = 8'd0;
                        presc_d = '0;
                    end
                end
                default: begin
                    state_d = C_ST_NOPASS;
                end
            endcase
        end
    end

    // Output decode: strobe is combinational, the rest follow the registers
    always_comb begin
        check_strobe = w_strobe;
        state        = state_q;
        unlocked     = (state_q == C_ST_UNLOCKED);
        locked_out   = (state_q == C_ST_LOCKOUT);
        fail_count   = fail_q;
        secs_left    = secs_q;
        alarm        = alarm_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_password_lockout_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_password_lockout_fsm
//  Description : Self-checking bench for password_lockout_fsm. A behavioural
//                model tracks the mode, failure count and remaining window
//                length in clock cycles; displayed seconds are derived from
//                the remaining cycles by ceiling division.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_password_lockout_fsm;

    localparam int TICK_DIV    = 4;
    localparam int MAX_TRIES   = 3;
    localparam int LOCK_SECS   = 2;
    localparam int UNLOCK_SECS = 3;

    localparam int M_NOPASS   = 0;
    localparam int M_LOCKED   = 1;
    localparam int M_UNLOCKED = 2;
    localparam int M_LOCKOUT  = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       check_btn;
    logic       relock_btn;
    logic       has_pass;
    logic       match;
    logic       check_strobe;
    logic [1:0] state;
    logic       unlocked;
    logic       locked_out;
    logic [3:0] fail_count;
    logic [7:0] secs_left;
    logic       alarm;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_mode;
    int m_fails;
    int m_rem;      // clock cycles left in the current timed window
    bit m_alarm;
    bit m_pc;       // previous check_btn level
    bit m_pr;       // previous relock_btn level

    password_lockout_fsm #(
        .TICK_DIV    (TICK_DIV),
        .MAX_TRIES   (MAX_TRIES),
        .LOCK_SECS   (LOCK_SECS),
        .UNLOCK_SECS (UNLOCK_SECS)
    ) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .check_btn    (check_btn),
        .relock_btn   (relock_btn),
        .has_pass     (has_pass),
        .match        (match),
        .check_strobe (check_strobe),
        .state        (state),
        .unlocked     (unlocked),
        .locked_out   (locked_out),
        .fail_count   (fail_count),
        .secs_left    (secs_left),
        .alarm        (alarm)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_NOPASS;
        m_fails = 0;
        m_rem   = 0;
        m_alarm = 1'b0;
        m_pc    = 1'b0;
        m_pr    = 1'b0;
    endtask

    task automatic compare_all(input bit exp_strobe);
        check_eq("check_strobe", int'(check_strobe), int'(exp_strobe));
        check_eq("state",        int'(state),        m_mode);
        check_eq("unlocked",     int'(unlocked),     int'(m_mode == M_UNLOCKED));
        check_eq("locked_out",   int'(locked_out),   int'(m_mode == M_LOCKOUT));
        check_eq("fail_count",   int'(fail_count),   m_fails);
        check_eq("secs_left",    int'(secs_left),    (m_rem + TICK_DIV - 1) / TICK_DIV);
        check_eq("alarm",        int'(alarm),        int'(m_alarm));
    endtask

    // Advance the model by one clock edge using the inputs applied in that cycle
    task automatic model_update(input bit hp, input bit cb, input bit rb,
                                input bit m, input bit strobe);
        bit relock_rise;
        relock_rise = rb && !m_pr;
        m_alarm = 1'b0;
        if (!hp) begin
            m_mode  = M_NOPASS;
            m_fails = 0;
            m_rem   = 0;
        end else begin
            case (m_mode)
                M_NOPASS: m_mode = M_LOCKED;
                M_LOCKED: begin
                    if (strobe) begin
                        if (m) begin
                            m_mode  = M_UNLOCKED;
                            m_fails = 0;
                            m_rem   = UNLOCK_SECS * TICK_DIV;
                        end else begin
                            m_fails = m_fails + 1;
                            if (m_fails == MAX_TRIES) begin
                                m_mode  = M_LOCKOUT;
                                m_rem   = LOCK_SECS * TICK_DIV;
                                m_alarm = 1'b1;
                            end
                        end
                    end
                end
                M_UNLOCKED: begin
                    m_rem = m_rem - 1;
                    if (relock_rise || m_rem == 0) begin
                        m_mode = M_LOCKED;
                        m_rem  = 0;
                    end
                end
                default: begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) begin
                        m_mode  = M_LOCKED;
                        m_fails = 0;
                    end
                end
            endcase
        end
        m_pc = cb;
        m_pr = rb;
    endtask

    // One cycle: apply inputs after the falling edge, compare, then clock the model
    task automatic step(input bit hp, input bit cb, input bit rb, input bit m);
        bit strobe;
        has_pass   = hp;
        check_btn  = cb;
        relock_btn = rb;
        match      = m;
        #1;
        strobe = cb && !m_pc && hp && (m_mode == M_LOCKED);
        compare_all(strobe);
        @(posedge clk);
        model_update(hp, cb, rb, m, strobe);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press(input bit m);
        step(1'b1, 1'b1, 1'b0, m);
        step(1'b1, 1'b0, 1'b0, m);
    endtask

    // Asynchronous reset placed between clock edges
    task automatic async_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all(1'b0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int pct;
        reset_n    = 1'b0;
        check_btn  = 1'b0;
        relock_btn = 1'b0;
        has_pass   = 1'b0;
        match      = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all(1'b0);
        reset_n = 1'b1;

        // No password: presses give no strobe, then has_pass moves to LOCKED
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);   // rise coincides with has_pass rising next
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);   // still held: no new rise
        idle(1);
        check_eq("t1_state_locked", int'(state), M_LOCKED);

        // Successful check and auto-relock after the full window
        press(1'b1);
        idle(14);

        // Three failures, lockout, ignored presses, expiry
        press(1'b0);
        press(1'b0);
        press(1'b0);
        press(1'b0);
        press(1'b1);
        idle(6);

        // Two failures then success, then manual relock mid-window
        press(1'b0);
        press(1'b0);
        press(1'b1);
        idle(3);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Drop has_pass late in a lockout
        press(1'b0);
        press(1'b0);
        press(1'b0);
        idle(3);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Async reset mid-unlock while check is held across release
        press(1'b1);
        idle(2);
        check_btn = 1'b1;
        async_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        press(1'b1);
        idle(3);

        // Randomized traffic with varying match bias
        for (int blk = 0; blk < 6; blk++) begin
            pct = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 90);
            for (int i = 0; i < 500; i++) begin
                step(($urandom_range(0, 99) != 0),
                     1'($urandom_range(0, 1)),
                     ($urandom_range(0, 15) == 0),
                     ($urandom_range(0, 99) < pct));
            end
            if (blk == 2) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
